// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder (dmem_responder, dmem_wbuf).
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B    = 2'b00,
        SIZE_H    = 2'b01,
        SIZE_W    = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    // Buffered word address is kept at full byte-address width minus the lane bits.
    localparam int unsigned WB_ADDR_W = 30;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] waddr;
        logic [3:0]           mask;
        logic [31:0]          data;
    } wb_entry_t;

    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~off[0];
            SIZE_W:  ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = '0;
        case (size)
            SIZE_B:  m = 4'b0001 << off;
            SIZE_H:  m = 4'b0011 << off;
            SIZE_W:  m = 4'b1111;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Circular store buffer with per-entry word-address compare and oldest-to-newest byte merge.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    output wb_entry_t                 head_entry,
    output logic [$clog2(WB_DEPTH):0] count,
    output logic                      full,
    input  logic [WB_ADDR_W-1:0]      lookup_waddr,
    output logic [3:0]                fwd_mask,
    output logic [31:0]               fwd_data
);
    localparam int unsigned PTR_W = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        entries_q [WB_DEPTH];
    wb_entry_t        entries_d [WB_DEPTH];
    logic             do_push, do_pop;
    logic [PTR_W-1:0] fwd_idx;

    assign full       = (count_q == CNT_W'(WB_DEPTH));
    assign count      = count_q;
    assign head_entry = entries_q[rd_ptr_q];
    assign do_pop     = pop && (count_q != '0);
    assign do_push    = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        entries_d = entries_q;
        if (do_push) begin
            entries_d[wr_ptr_q] = push_entry;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    // Walk from head to tail so a younger matching store overrides older bytes.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (entries_q[fwd_idx].waddr == lookup_waddr)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (entries_q[fwd_idx].mask[b]) begin
                        fwd_mask[b]        = 1'b1;
                        fwd_data[8*b +: 8] = entries_q[fwd_idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores into a word RAM.
// Define DMEM_WBUF_EN to post stores through dmem_wbuf with load forwarding.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WB_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [31:0] readdata,
    output logic        readvalid,
    output logic        stall,
    output logic        misalign
);
    logic [ADDR_WIDTH-1:0] req_waddr;
    logic [1:0]            req_off;
    logic                  aligned, accept, st_acc, ld_acc;
    logic [3:0]            req_mask;
    logic [31:0]           req_lane_data;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [3:0]            ram_wmask;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [31:0]           ram_q [2**ADDR_WIDTH];

    logic [31:0] load_word, shifted, extended;
    logic [31:0] readdata_q, readdata_d;
    logic        readvalid_q, readvalid_d;
    logic        misalign_q, misalign_d;
    logic        unused_adr_hi;

    assign unused_adr_hi = ^dataadr[31:ADDR_WIDTH+2];

    assign req_waddr     = dataadr[ADDR_WIDTH+1:2];
    assign req_off       = dataadr[1:0];
    assign aligned       = size_aligned(mem_size, req_off);
    assign req_mask      = byte_mask(mem_size, req_off);
    assign req_lane_data = writedata << {req_off, 3'b000};

    // A store wins over a load presented in the same cycle.
    assign accept = (memwrite || memread) && !stall;
    assign st_acc = accept && memwrite && aligned;
    assign ld_acc = accept && memread && !memwrite && aligned;

`ifdef DMEM_WBUF_EN
    wb_entry_t                 push_entry, head_entry;
    logic [$clog2(WB_DEPTH):0] wb_count;
    logic                      wb_full, drain;
    logic [3:0]                fwd_mask;
    logic [31:0]               fwd_data;
    logic                      unused_head_hi;

    assign push_entry = '{waddr: WB_ADDR_W'(req_waddr), mask: req_mask, data: req_lane_data};
    // Drain only on cycles without a valid accepted request; full blocks requests, so it always drains.
    assign drain      = (wb_count != '0) && !st_acc && !ld_acc;

    dmem_wbuf #(
        .WB_DEPTH(WB_DEPTH)
    ) u_wbuf (
        .clk          (clk),
        .rst          (rst),
        .push         (st_acc),
        .push_entry   (push_entry),
        .pop          (drain),
        .head_entry   (head_entry),
        .count        (wb_count),
        .full         (wb_full),
        .lookup_waddr (WB_ADDR_W'(req_waddr)),
        .fwd_mask     (fwd_mask),
        .fwd_data     (fwd_data)
    );

    assign unused_head_hi = ^head_entry.waddr[WB_ADDR_W-1:ADDR_WIDTH];
    assign stall     = wb_full;
    assign ram_we    = drain;
    assign ram_waddr = head_entry.waddr[ADDR_WIDTH-1:0];
    assign ram_wmask = head_entry.mask;
    assign ram_wdata = head_entry.data;

    always_comb begin
        load_word = ram_rdata;
        for (int unsigned b = 0; b < 4; b++) begin
            if (fwd_mask[b]) begin
                load_word[8*b +: 8] = fwd_data[8*b +: 8];
            end
        end
    end
`else
    assign stall     = 1'b0;
    assign ram_we    = st_acc;
    assign ram_waddr = req_waddr;
    assign ram_wmask = req_mask;
    assign ram_wdata = req_lane_data;
    assign load_word = ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (ram_wmask[b]) begin
                    ram_q[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ram_rdata = ram_q[req_waddr];

    // Lane select and extension happen before the output register, so the request fields need no staging.
    always_comb begin
        shifted  = load_word >> {req_off, 3'b000};
        extended = load_word;
        case (mem_size)
            SIZE_B:  extended = mem_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  extended = mem_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: extended = load_word;
        endcase
    end

    always_comb begin
        readdata_d  = ld_acc ? extended : readdata_q;
        readvalid_d = ld_acc;
        misalign_d  = accept && !aligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_q  <= '0;
            readvalid_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            readdata_q  <= readdata_d;
            readvalid_q <= readvalid_d;
            misalign_q  <= misalign_d;
        end
    end

    assign readdata  = readdata_q;
    assign readvalid = readvalid_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; expectations follow DMEM_WBUF_EN.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [1:0]  mem_size = 2'b10;
    logic        mem_unsigned = 1'b0;
    logic [31:0] readdata;
    logic        readvalid;
    logic        stall;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DMEM_WBUF_EN
    localparam bit BUFFERED = 1'b1;
`else
    localparam bit BUFFERED = 1'b0;
`endif

    dmem_responder #(
        .ADDR_WIDTH (10),
        .WB_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memwrite     (memwrite),
        .memread      (memread),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .readdata     (readdata),
        .readvalid    (readvalid),
        .stall        (stall),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic re, input logic [31:0] adr,
                           input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        memwrite = we; memread = re; dataadr = adr;
        writedata = wd; mem_size = sz; mem_unsigned = uns;
    endtask

    task automatic set_idle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] wd, input logic [1:0] sz);
        set_req(1'b1, 1'b0, adr, wd, sz, 1'b0);
        tick();
        set_idle();
    endtask

    task automatic load(input logic [31:0] adr, input logic [1:0] sz, input logic uns);
        set_req(1'b0, 1'b1, adr, 32'h0, sz, uns);
        tick();
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
        n_checks++; if (readvalid !== 1'b0) begin n_fail++; $display("FAIL reset_readvalid: got %b expected 0", readvalid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        store(32'd200, 32'd300, 2'b10);
        load(32'd200, 2'b10, 1'b0);
        n_checks++; if (readvalid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid: got %b expected 1", readvalid); end
        n_checks++; if (readdata !== 32'd300) begin n_fail++; $display("FAIL fwd_data: got %0d expected 300", readdata); end
        idle_cycles(5);
        n_checks++; if (readvalid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b expected 0", readvalid); end
        n_checks++; if (readdata !== 32'd300) begin n_fail++; $display("FAIL data_held: got %0d expected 300", readdata); end
        load(32'd200, 2'b10, 1'b0);
        n_checks++; if (readdata !== 32'd300) begin n_fail++; $display("FAIL ram_data: got %0d expected 300", readdata); end
    endtask

    task automatic test_byte_merge();
        store(32'd204, 32'h11223344, 2'b10);
        store(32'd205, 32'h123456AA, 2'b00);
        load(32'd204, 2'b10, 1'b0);
        n_checks++; if (readdata !== 32'h1122AA44) begin n_fail++; $display("FAIL merge_lw: got %h expected 1122aa44", readdata); end
        load(32'd205, 2'b00, 1'b1);
        n_checks++; if (readdata !== 32'h000000AA) begin n_fail++; $display("FAIL lbu: got %h expected 000000aa", readdata); end
        load(32'd205, 2'b00, 1'b0);
        n_checks++; if (readdata !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb: got %h expected ffffffaa", readdata); end
        load(32'd206, 2'b01, 1'b0);
        n_checks++; if (readdata !== 32'h00001122) begin n_fail++; $display("FAIL lh_pos: got %h expected 00001122", readdata); end
        idle_cycles(5);
    endtask

    task automatic test_half();
        store(32'd210, 32'hDEAD8001, 2'b01);
        load(32'd210, 2'b01, 1'b0);
        n_checks++; if (readdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h expected ffff8001", readdata); end
        load(32'd210, 2'b01, 1'b1);
        n_checks++; if (readdata !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h expected 00008001", readdata); end
        idle_cycles(5);
    endtask

    task automatic test_back_to_back();
        int  stall_cycles;
        bit  accepted;
        logic [31:0] exp_word;
        idle_cycles(6);
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 32'd220 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 2'b10, 1'b0);
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_nostall_%0d: got %b expected 0", i, stall); end
            tick();
        end
        set_req(1'b1, 1'b0, 32'd236, 32'hC0DE0004, 2'b10, 1'b0);
        stall_cycles = 0;
        accepted = 1'b0;
        for (int k = 0; k < 8 && !accepted; k++) begin
            if (stall) stall_cycles++;
            else accepted = 1'b1;
            tick();
        end
        set_idle();
        n_checks++; if (!accepted) begin n_fail++; $display("FAIL b2b_accept: got not accepted expected accepted within 8 cycles"); end
        n_checks++; if (stall_cycles != (BUFFERED ? 1 : 0)) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d expected %0d", stall_cycles, BUFFERED ? 1 : 0); end
        n_checks++; if (stall !== BUFFERED) begin n_fail++; $display("FAIL b2b_full_again: got %b expected %b", stall, BUFFERED); end
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_word = 32'hC0DE0000 + 32'(i);
            load(32'd220 + 32'(4 * i), 2'b10, 1'b0);
            n_checks++; if (readvalid !== 1'b1 || readdata !== exp_word) begin n_fail++; $display("FAIL b2b_read_%0d: got %h/%b expected %h/1", i, readdata, readvalid, exp_word); end
        end
        idle_cycles(6);
    endtask

    task automatic test_misalign();
        load(32'd201, 2'b10, 1'b0);
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_lw: got %b expected 1", misalign); end
        n_checks++; if (readvalid !== 1'b0) begin n_fail++; $display("FAIL mis_lw_valid: got %b expected 0", readvalid); end
        store(32'd203, 32'h0000FFFF, 2'b01);
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_sh: got %b expected 1", misalign); end
        set_req(1'b0, 1'b1, 32'd200, 32'h0, 2'b11, 1'b0);
        tick();
        set_idle();
        n_checks++; if (misalign !== 1'b1 || readvalid !== 1'b0) begin n_fail++; $display("FAIL mis_size11: got %b/%b expected 1/0", misalign, readvalid); end
        tick();
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b expected 0", misalign); end
        idle_cycles(4);
        load(32'd200, 2'b10, 1'b0);
        n_checks++; if (readdata !== 32'd300) begin n_fail++; $display("FAIL mis_ram_intact: got %0d expected 300", readdata); end
    endtask

    task automatic test_store_load_same();
        set_req(1'b1, 1'b1, 32'd244, 32'h00000099, 2'b10, 1'b0);
        tick();
        set_idle();
        n_checks++; if (readvalid !== 1'b0) begin n_fail++; $display("FAIL both_valid: got %b expected 0", readvalid); end
        load(32'd244, 2'b10, 1'b0);
        n_checks++; if (readdata !== 32'h00000099) begin n_fail++; $display("FAIL both_store: got %h expected 00000099", readdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_word;
        store(32'd240, 32'h00000055, 2'b10);
        idle_cycles(5);
        store(32'd240, 32'h00000007, 2'b10);
        rst = 1'b1;
        #1;
        n_checks++; if (readdata !== 32'h0 || readvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: got %h/%b expected 00000000/0", readdata, readvalid); end
        n_checks++; if (stall !== 1'b0 || misalign !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b/%b expected 0/0", stall, misalign); end
        tick();
        rst = 1'b0;
        tick();
        exp_word = BUFFERED ? 32'h00000055 : 32'h00000007;
        load(32'd240, 2'b10, 1'b0);
        n_checks++; if (readdata !== exp_word) begin n_fail++; $display("FAIL rst_mid_ram: got %h expected %h", readdata, exp_word); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_byte_merge();
        test_half();
        test_back_to_back();
        test_misalign();
        test_store_load_same();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
